// File: rtl/key_event_pkg.sv
// Shared types and constants for the key_event switch front end.
// Holds the per-key FSM state encoding, default timing parameters and counter widths.
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_REL_DB   = 2'd3
  } key_state_t;

  localparam int NUM_KEYS = 4;
  localparam int DB_W     = 4;
  localparam int HOLD_W   = 8;

  localparam int DEF_SAMPLE_DIV   = 500000;
  localparam int DEF_STABLE_CNT   = 3;
  localparam int DEF_HOLD_TICKS   = 50;
  localparam int DEF_REPEAT_TICKS = 10;

endpackage

// File: rtl/key_event_if.sv
// Key bus between the button front end (slave) and its consumer (master).
// Plain wires with no handshake: every event is a one-cycle pulse and there is no backpressure.
interface key_event_if;
  import key_event_pkg::*;

  logic [NUM_KEYS-1:0] i_sw;
  logic [NUM_KEYS-1:0] o_level;
  logic [NUM_KEYS-1:0] o_press;
  logic [NUM_KEYS-1:0] o_release;
  logic [NUM_KEYS-1:0] o_repeat;
  logic                o_tick;

  modport master (output i_sw, input o_level, o_press, o_release, o_repeat, o_tick);
  modport slave  (input i_sw, output o_level, o_press, o_release, o_repeat, o_tick);

endinterface

// File: rtl/key_fsm.sv
// Single-key debounce/hold FSM advanced on sample ticks; outputs registered, 1 clk after the tick.
// No backpressure. Auto-repeat only when KEY_EVENT_REPEAT_EN is defined.
module key_fsm
  import key_event_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT
`ifdef KEY_EVENT_REPEAT_EN
  ,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_s,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam logic [DB_W-1:0] DB_TGT = DB_W'(STABLE_CNT);

  key_state_t      r_state;
  logic [DB_W-1:0] r_db;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic [DB_W-1:0] w_db_inc;

  assign w_db_inc = r_db + DB_W'(1);

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [HOLD_W-1:0] HOLD_TGT = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_TICKS + REPEAT_TICKS);

  logic [HOLD_W-1:0] r_hold;
  logic              r_repeat;
  logic [HOLD_W-1:0] w_hold_inc;

  assign w_hold_inc = r_hold + HOLD_W'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_db      <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      r_hold    <= '0;
      r_repeat  <= 1'b0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      r_repeat  <= 1'b0;
`endif
      if (i_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (i_s) begin
              if (STABLE_CNT == 1) begin
                r_state <= ST_PRESSED;
                r_level <= 1'b1;
                r_press <= 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
                r_hold  <= '0;
`endif
              end else begin
                r_state <= ST_PRESS_DB;
                r_db    <= DB_W'(1);
              end
            end
          end
          ST_PRESS_DB: begin
            if (!i_s) begin
              r_state <= ST_IDLE;
              r_db    <= '0;
            end else if (w_db_inc == DB_TGT) begin
              r_state <= ST_PRESSED;
              r_db    <= '0;
              r_level <= 1'b1;
              r_press <= 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
              r_hold  <= '0;
`endif
            end else begin
              r_db <= w_db_inc;
            end
          end
          ST_PRESSED: begin
            if (!i_s) begin
              if (STABLE_CNT == 1) begin
                r_state   <= ST_IDLE;
                r_level   <= 1'b0;
                r_release <= 1'b1;
              end else begin
                r_state <= ST_REL_DB;
                r_db    <= DB_W'(1);
              end
            end
`ifdef KEY_EVENT_REPEAT_EN
            // Past HOLD_TICKS the count cycles HOLD..HOLD+REPEAT, one repeat per lap.
            else if (w_hold_inc == HOLD_TOP) begin
              r_hold   <= HOLD_TGT;
              r_repeat <= 1'b1;
            end else begin
              r_hold   <= w_hold_inc;
              r_repeat <= (w_hold_inc == HOLD_TGT);
            end
`endif
          end
          ST_REL_DB: begin
            if (i_s) begin
              r_state <= ST_PRESSED;
              r_db    <= '0;
            end else if (w_db_inc == DB_TGT) begin
              r_state   <= ST_IDLE;
              r_db      <= '0;
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_db <= w_db_inc;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
`ifdef KEY_EVENT_REPEAT_EN
  assign o_repeat  = r_repeat;
`else
  assign o_repeat  = 1'b0;
`endif

endmodule

// File: rtl/key_event.sv
// Four-key front end: 2-flop sync, shared sample tick, per-key debounce FSMs; no backpressure.
// Press latency 2 clk + STABLE_CNT ticks + 1 clk; optional auto-repeat via KEY_EVENT_REPEAT_EN.
module key_event
  import key_event_pkg::*;
#(
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int STABLE_CNT   = DEF_STABLE_CNT,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic        clk,
  input  logic        rst_n,
  key_event_if.slave  bus
);

  localparam int                CNT_W   = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

  if (SAMPLE_DIV < 2 || STABLE_CNT < 1 || STABLE_CNT > 15 ||
      HOLD_TICKS + REPEAT_TICKS > 255) begin : g_bad_cfg
    $error("key_event: parameter out of range");
  end

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_KEYS-1:0] w_s;
  logic                w_tick;
  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] w_repeat;

  // Raw buttons idle high, so the chain resets to all-ones (released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.i_sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s    = ~r_sync2;
  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_fsm #(
      .STABLE_CNT   (STABLE_CNT)
`ifdef KEY_EVENT_REPEAT_EN
      ,
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
`endif
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_tick    (w_tick),
      .i_s       (w_s[k]),
      .o_level   (w_level[k]),
      .o_press   (w_press[k]),
      .o_release (w_release[k]),
      .o_repeat  (w_repeat[k])
    );
  end

  assign bus.o_level   = w_level;
  assign bus.o_press   = w_press;
  assign bus.o_release = w_release;
  assign bus.o_repeat  = w_repeat;
  assign bus.o_tick    = w_tick;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: directed scenarios plus random key traffic, checked every cycle
// against a tick-level model built from run lengths of sampled key values.
module tb_key_event;
  import key_event_pkg::*;

  localparam int SAMPLE_DIV   = 10;
  localparam int STABLE_CNT   = 3;
  localparam int HOLD_TICKS   = 5;
  localparam int REPEAT_TICKS = 2;

  logic clk;
  logic rst_n;
  key_event_if bus();

  key_event #(
    .SAMPLE_DIV   (SAMPLE_DIV),
    .STABLE_CNT   (STABLE_CNT),
    .HOLD_TICKS   (HOLD_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: key debounced level flips once STABLE_CNT consecutive
  // tick samples disagree with it; held_ticks counts steady-held samples.
  int         m_cnt;
  logic [3:0] m_p1, m_p2;
  logic [3:0] m_lvl, e_press, e_rel, e_rep;
  logic       m_s;
  int         m_run  [4];
  int         m_held [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_p1 = '1; m_p2 = '1;
      m_lvl = '0; e_press = '0; e_rel = '0; e_rep = '0;
      for (int k = 0; k < 4; k++) begin m_run[k] = 0; m_held[k] = 0; end
    end else begin
      e_press = '0; e_rel = '0; e_rep = '0;
      if (m_cnt == SAMPLE_DIV - 1) begin
        for (int k = 0; k < 4; k++) begin
          m_s = ~m_p2[k];
          if (m_s != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == STABLE_CNT) begin
              m_lvl[k] = m_s; m_run[k] = 0; m_held[k] = 0;
              if (m_s) e_press[k] = 1'b1; else e_rel[k] = 1'b1;
            end
          end else begin
            if (m_lvl[k] && m_run[k] == 0) begin
              m_held[k]++;
`ifdef KEY_EVENT_REPEAT_EN
              if (m_held[k] >= HOLD_TICKS && (m_held[k] - HOLD_TICKS) % REPEAT_TICKS == 0)
                e_rep[k] = 1'b1;
`endif
            end
            m_run[k] = 0;
          end
        end
      end
      m_cnt = (m_cnt == SAMPLE_DIV - 1) ? 0 : m_cnt + 1;
      m_p2 = m_p1;
      m_p1 = bus.i_sw;
    end
  end

  int   n_press [4];
  int   n_rel   [4];
  int   n_rep   [4];
  logic saw_p, saw_r;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 4; k++) begin n_press[k] = 0; n_rel[k] = 0; n_rep[k] = 0; end
    saw_p = 1'b0; saw_r = 1'b0;
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("level",   bus.o_level,   m_lvl);
      chk("press",   bus.o_press,   e_press);
      chk("release", bus.o_release, e_rel);
      chk("repeat",  bus.o_repeat,  e_rep);
      chk("tick",    {3'b000, bus.o_tick}, {3'b000, (m_cnt == SAMPLE_DIV - 1)});
      chk("press_and_release", bus.o_press & bus.o_release, 4'b0000);
      for (int k = 0; k < 4; k++) begin
        if (bus.o_press[k] === 1'b1)   n_press[k]++;
        if (bus.o_release[k] === 1'b1) n_rel[k]++;
        if (bus.o_repeat[k] === 1'b1)  n_rep[k]++;
      end
      if (bus.o_press === 4'b1001)   saw_p = 1'b1;
      if (bus.o_release === 4'b1001) saw_r = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_sw = 4'b1111;
    clr_counts();
    @(posedge clk);
    step(3);
    chk("reset_level", bus.o_level, 4'b0000);
    rst_n = 1'b1;

    // Clean press on key 0
    clr_counts();
    bus.i_sw[0] = 1'b0;
    step(50);
    chk_int("clean_press_cnt", n_press[0], 1);
    chk("clean_level", bus.o_level, 4'b0001);
    chk_int("clean_other_press", n_press[1] + n_press[2] + n_press[3], 0);
    bus.i_sw[0] = 1'b1;
    step(50);
    chk_int("clean_release_cnt", n_rel[0], 1);

    // Bounce on key 1: alternate ticks, then steady
    clr_counts();
    for (int i = 0; i < 4; i++) begin
      bus.i_sw[1] = i[0];
      step(SAMPLE_DIV);
    end
    chk_int("bounce_no_press", n_press[1], 0);
    bus.i_sw[1] = 1'b0;
    step(50);
    chk_int("bounce_press_cnt", n_press[1], 1);
    bus.i_sw[1] = 1'b1;
    step(50);

    // Release glitch on key 2
    clr_counts();
    bus.i_sw[2] = 1'b0;
    step(50);
    bus.i_sw[2] = 1'b1;
    step(2 * SAMPLE_DIV);
    bus.i_sw[2] = 1'b0;
    step(50);
    chk_int("glitch_no_release", n_rel[2], 0);
    chk_int("glitch_single_press", n_press[2], 1);
    chk("glitch_level", bus.o_level, 4'b0100);
    bus.i_sw[2] = 1'b1;
    step(50);

    // Long hold on key 3: about 11-12 held ticks after the press
    clr_counts();
    bus.i_sw[3] = 1'b0;
    step(145);
    bus.i_sw[3] = 1'b1;
    step(50);
`ifdef KEY_EVENT_REPEAT_EN
    chk_int("hold_repeat_cnt", n_rep[3], 4);
`else
    chk_int("hold_repeat_cnt", n_rep[3], 0);
`endif
    chk_int("hold_release_cnt", n_rel[3], 1);

    // Simultaneous keys 0 and 3
    clr_counts();
    bus.i_sw = 4'b0110;
    step(50);
    chk("simul_press", {3'b000, saw_p}, 4'b0001);
    bus.i_sw = 4'b1111;
    step(50);
    chk("simul_release", {3'b000, saw_r}, 4'b0001);

    // Reset while key 0 is held
    bus.i_sw[0] = 1'b0;
    step(60);
    clr_counts();
    rst_n = 1'b0;
    step(3);
    chk("rst_outputs", bus.o_level | bus.o_press | bus.o_release | bus.o_repeat, 4'b0000);
    rst_n = 1'b1;
    step(50);
    chk_int("rst_no_release", n_rel[0], 0);
    chk_int("rst_repress", n_press[0], 1);
    bus.i_sw = 4'b1111;
    step(50);

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      bus.i_sw = 4'($urandom);
      step($urandom_range(1, 45));
    end
    bus.i_sw = 4'b1111;
    step(60);
    chk("final_level", bus.o_level, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
